// File: rtl/sysclk_mmcm_sequencer.sv
// Bring-up and recovery sequencer for the system clock MMCM.
// Drives MMCM reset, qualifies LOCKED, retries on timeout and restarts on lock loss.
module sysclk_mmcm_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned MAX_RETRIES   = 4,
    parameter int unsigned TIMER_WIDTH   = 17
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       locked_i,
    input  logic       restart_i,
    input  logic       clear_count_i,
    output logic       mmcm_rst_o,
    output logic       ready_o,
    output logic       fail_o,
    output logic [2:0] state_o,
    output logic [3:0] retry_count_o,
    output logic [7:0] lock_loss_count_o
);

    // state      | meaning
    // RESET_HOLD | MMCM held in reset for RST_CYCLES
    // WAIT_LOCK  | reset released, waiting for locked_s (bounded by LOCK_TIMEOUT)
    // SETTLE     | locked_s must stay high for SETTLE_CYCLES
    // READY      | clock usable; a lock drop restarts the sequence
    // FAIL       | attempts exhausted, MMCM held in reset until restart/reset
    typedef enum logic [2:0] {
        S_RESET_HOLD = 3'd0,
        S_WAIT_LOCK  = 3'd1,
        S_SETTLE     = 3'd2,
        S_READY      = 3'd3,
        S_FAIL       = 3'd4
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] RST_LAST    = TIMER_WIDTH'(RST_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LAST = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] SETTLE_LAST = TIMER_WIDTH'(SETTLE_CYCLES - 1);
    localparam logic [3:0]             RETRY_MAX   = 4'(MAX_RETRIES);

    logic                   sync1_q;
    logic                   locked_s_q;
    state_t                 state_q, state_d;
    logic [TIMER_WIDTH-1:0] timer_q, timer_d;
    logic [3:0]             retry_q, retry_d;
    logic [7:0]             loss_cnt_q, loss_cnt_d;
    logic                   mmcm_rst_q, mmcm_rst_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;
    logic                   lost_lock;
    logic [3:0]             retry_inc;

    always_comb begin
        state_d    = state_q;
        retry_d    = retry_q;
        loss_cnt_d = loss_cnt_q;
        timer_d    = timer_q + 1'b1;
        lost_lock  = (state_q == S_READY) && !locked_s_q;
        retry_inc  = retry_q + 4'd1;

        // Clear beats a same-cycle increment.
        if (clear_count_i) begin
            loss_cnt_d = '0;
        end else if (lost_lock && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end

        if (restart_i) begin
            state_d = S_RESET_HOLD;
            retry_d = '0;
        end else begin
            case (state_q)
                S_RESET_HOLD: begin
                    if (timer_q == RST_LAST) state_d = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (locked_s_q) begin
                        state_d = S_SETTLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_HOLD;
                    end
                end
                S_SETTLE: begin
                    if (!locked_s_q) begin
                        retry_d = retry_inc;
                        state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_RESET_HOLD;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d = S_READY;
                        retry_d = '0;
                    end
                end
                S_READY: begin
                    if (lost_lock) begin
                        state_d = S_RESET_HOLD;
                        retry_d = '0;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_RESET_HOLD;
                    retry_d = '0;
                end
            endcase
        end

        if (restart_i || (state_d != state_q)) timer_d = '0;

        // Outputs are decoded from the next state so they register alongside it.
        mmcm_rst_d = (state_d == S_RESET_HOLD) || (state_d == S_FAIL);
        ready_d    = (state_d == S_READY);
        fail_d     = (state_d == S_FAIL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
            state_q    <= S_RESET_HOLD;
            timer_q    <= '0;
            retry_q    <= '0;
            loss_cnt_q <= '0;
            mmcm_rst_q <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            sync1_q    <= locked_i;
            locked_s_q <= sync1_q;
            state_q    <= state_d;
            timer_q    <= timer_d;
            retry_q    <= retry_d;
            loss_cnt_q <= loss_cnt_d;
            mmcm_rst_q <= mmcm_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    assign mmcm_rst_o        = mmcm_rst_q;
    assign ready_o           = ready_q;
    assign fail_o            = fail_q;
    assign state_o           = state_q;
    assign retry_count_o     = retry_q;
    assign lock_loss_count_o = loss_cnt_q;

endmodule

// File: tb/tb_sysclk_mmcm_sequencer.sv
// Self-checking bench for sysclk_mmcm_sequencer: timeline model plus directed literal pins.
// Cycle c = outputs after c clock edges with reset low; an input event "at cycle c" is first sampled by that edge.
module tb_sysclk_mmcm_sequencer;
    localparam int RST_N = 4;
    localparam int TO_N  = 20;
    localparam int SET_N = 8;
    localparam int MAX_R = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       locked_i = 1'b0;
    logic       restart_i = 1'b0;
    logic       clear_count_i = 1'b0;
    logic       mmcm_rst_o, ready_o, fail_o;
    logic [2:0] state_o;
    logic [3:0] retry_count_o;
    logic [7:0] lock_loss_count_o;

    int checks = 0;
    int failures = 0;
    int k = 0;

    always #5 clk = ~clk;

    sysclk_mmcm_sequencer #(
        .RST_CYCLES(RST_N), .LOCK_TIMEOUT(TO_N), .SETTLE_CYCLES(SET_N),
        .MAX_RETRIES(MAX_R), .TIMER_WIDTH(8)
    ) dut (
        .clk(clk), .reset(reset), .locked_i(locked_i), .restart_i(restart_i),
        .clear_count_i(clear_count_i), .mmcm_rst_o(mmcm_rst_o), .ready_o(ready_o),
        .fail_o(fail_o), .state_o(state_o), .retry_count_o(retry_count_o),
        .lock_loss_count_o(lock_loss_count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, k);
        end
    endtask

    // Timeline model: phase plus edge index of phase entry; locked_s is the
    // recorded locked_i history delayed by two edges, zeroed across reset.
    int  m_phase = 0, m_entry = 0, m_retries = 0, m_losses = 0;
    bit  m_valid = 1'b0;
    bit  lh[$];
    bit  rh[$];

    task automatic m_enter(input int ph, input int j);
        m_phase = ph;
        m_entry = j;
    endtask

    task automatic m_failed_attempt(input int j);
        m_retries++;
        m_enter((m_retries == MAX_R) ? 4 : 0, j);
    endtask

    always @(posedge clk) begin
        int  j;
        int  el;
        bit  ls;
        j  = lh.size();
        ls = (j >= 2 && !rh[j-1]) ? lh[j-2] : 1'b0;
        el = j - 1 - m_entry;
        if (reset) begin
            m_enter(0, j);
            m_retries = 0;
            m_losses  = 0;
            k = 0;
        end else begin
            k++;
            if (clear_count_i) m_losses = 0;
            else if (m_phase == 3 && !ls && m_losses < 255) m_losses++;
            if (restart_i) begin
                m_enter(0, j);
                m_retries = 0;
            end else if (m_phase == 0) begin
                if (el == RST_N - 1) m_enter(1, j);
            end else if (m_phase == 1) begin
                if (ls) m_enter(2, j);
                else if (el == TO_N - 1) m_failed_attempt(j);
            end else if (m_phase == 2) begin
                if (!ls) m_failed_attempt(j);
                else if (el == SET_N - 1) begin
                    m_enter(3, j);
                    m_retries = 0;
                end
            end else if (m_phase == 3) begin
                if (!ls) begin
                    m_enter(0, j);
                    m_retries = 0;
                end
            end
        end
        lh.push_back(reset ? 1'b0 : locked_i);
        rh.push_back(reset);
        m_valid = 1'b1;
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("m_state", state_o, m_phase);
            check("m_mmcm_rst", mmcm_rst_o, (m_phase == 0 || m_phase == 4) ? 1 : 0);
            check("m_ready", ready_o, (m_phase == 3) ? 1 : 0);
            check("m_fail", fail_o, (m_phase == 4) ? 1 : 0);
            check("m_retry", retry_count_o, m_retries);
            check("m_loss_cnt", lock_loss_count_o, m_losses);
        end
    end

    task automatic run_until(input int c);
        int guard = 0;
        while (k < c && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic wait_state(input string name, input logic [2:0] st, input int budget);
        int t = 0;
        while (state_o !== st && t < budget) begin
            @(negedge clk);
            t++;
        end
        check(name, state_o, st);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state_o, 0);
        check({tag, "_mmcm_rst"}, mmcm_rst_o, 1);
        check({tag, "_ready"}, ready_o, 0);
        check({tag, "_fail"}, fail_o, 0);
        check({tag, "_retry"}, retry_count_o, 0);
        check({tag, "_loss_cnt"}, lock_loss_count_o, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", k);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        repeat (3) @(negedge clk);
        check_reset_values("por");
        reset = 1'b0;

        // Nominal bring-up
        run_until(3);  check("nom_rst_c3", mmcm_rst_o, 1);
        run_until(4);  check("nom_rst_c4", mmcm_rst_o, 0);
        check("nom_wait_c4", state_o, 1);
        run_until(9);  locked_i = 1'b1;
        run_until(11); check("nom_wait_c11", state_o, 1);
        run_until(12); check("nom_settle_c12", state_o, 2);
        run_until(19); check("nom_ready_c19", ready_o, 0);
        run_until(20); check("nom_ready_c20", ready_o, 1);
        check("nom_retry", retry_count_o, 0);

        // Lock loss in READY, repeated to saturation
        for (int i = 0; i < 300; i++) begin
            hi = 0;
            locked_i = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (mmcm_rst_o) hi++;
            end
            locked_i = 1'b1;
            for (int t = 0; t < 100 && !ready_o; t++) begin
                @(negedge clk);
                if (mmcm_rst_o) hi++;
            end
            if (i == 0) begin
                check("loss1_ready", ready_o, 1);
                check("loss1_count", lock_loss_count_o, 1);
                check("loss1_rst_cycles", hi, RST_N);
            end
        end
        check("loss_saturated", lock_loss_count_o, 255);

        // Clear coinciding with a lock loss: clear wins
        locked_i = 1'b0;
        @(negedge clk); @(negedge clk);
        clear_count_i = 1'b1;
        @(negedge clk);
        clear_count_i = 1'b0;
        check("clr_loss_count", lock_loss_count_o, 0);
        check("clr_loss_state", state_o, 0);
        locked_i = 1'b1;
        wait_state("clr_relock", 3'd3, 100);

        // Restart coinciding with a lock loss: loss still counted
        locked_i = 1'b0;
        @(negedge clk); @(negedge clk);
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        check("rst_loss_state", state_o, 0);
        check("rst_loss_count", lock_loss_count_o, 1);
        locked_i = 1'b1;
        wait_state("rst_loss_relock", 3'd3, 100);

        // Drop lock for good from READY: loss counted, then attempts exhaust
        locked_i = 1'b0;
        wait_state("perm_fail", 3'd4, 300);
        check("perm_fail_o", fail_o, 1);
        check("perm_retry", retry_count_o, MAX_R);
        check("perm_loss_count", lock_loss_count_o, 2);
        repeat (10) @(negedge clk);
        check("perm_fail_held", state_o, 4);

        // Restart from FAIL
        restart_i = 1'b1;
        @(negedge clk);
        restart_i = 1'b0;
        check("restart_state", state_o, 0);
        check("restart_fail", fail_o, 0);
        check("restart_retry", retry_count_o, 0);
        check("restart_loss_count", lock_loss_count_o, 2);

        // Reset mid-SETTLE
        locked_i = 1'b1;
        wait_state("mid_settle", 3'd2, 100);
        repeat (3) @(negedge clk);
        check("mid_settle_still", state_o, 2);
        reset = 1'b1;
        @(negedge clk);
        check_reset_values("midrst");
        locked_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Timeout exhaustion with locked_i held low
        run_until(23); check("to_retry_c23", retry_count_o, 0);
        run_until(24); check("to_retry_c24", retry_count_o, 1);
        check("to_state_c24", state_o, 0);
        run_until(48); check("to_retry_c48", retry_count_o, 2);
        run_until(71); check("to_state_c71", state_o, 1);
        run_until(72); check("to_state_c72", state_o, 4);
        check("to_fail_c72", fail_o, 1);
        check("to_mmcm_c72", mmcm_rst_o, 1);
        check("to_retry_c72", retry_count_o, 3);
        run_until(150); check("to_fail_held", fail_o, 1);

        // Settle abort
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        run_until(9);  locked_i = 1'b1;
        run_until(12); check("sa_settle_c12", state_o, 2);
        run_until(14); locked_i = 1'b0;
        run_until(16); check("sa_settle_c16", state_o, 2);
        run_until(17); check("sa_hold_c17", state_o, 0);
        check("sa_retry_c17", retry_count_o, 1);
        run_until(39); locked_i = 1'b1;
        wait_state("sa_ready", 3'd3, 100);
        check("sa_ready_retry", retry_count_o, 0);
        check("sa_ready_o", ready_o, 1);

        @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
